// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the cpu_loader slice: code image size, loader
// state encodings and frame length limit.
package cpu_loader_pkg;

  localparam int cpu_code_sz = 256;
  localparam int cpu_loader_byte_sz = 8;
  localparam int cpu_loader_max_len = cpu_code_sz / cpu_loader_byte_sz;
  localparam int cpu_loader_cnt_sz = $clog2(cpu_loader_max_len) + 1;

  localparam int cpu_loader_state_sz = 3;
  localparam logic [cpu_loader_state_sz-1:0] cpu_loader_state_idle  = 3'd0;
  localparam logic [cpu_loader_state_sz-1:0] cpu_loader_state_data  = 3'd1;
  localparam logic [cpu_loader_state_sz-1:0] cpu_loader_state_check = 3'd2;
  localparam logic [cpu_loader_state_sz-1:0] cpu_loader_state_run   = 3'd3;
  localparam logic [cpu_loader_state_sz-1:0] cpu_loader_state_err   = 3'd4;

  typedef enum logic [cpu_loader_state_sz-1:0] {
    ST_IDLE  = cpu_loader_state_idle,
    ST_DATA  = cpu_loader_state_data,
    ST_CHECK = cpu_loader_state_check,
    ST_RUN   = cpu_loader_state_run,
    ST_ERR   = cpu_loader_state_err
  } cpu_loader_state_e;

  // A LEN byte is usable when it names 1..max_len payload bytes.
  function automatic logic len_valid(input logic [cpu_loader_byte_sz-1:0] len);
    return (len != '0) && (len <= cpu_loader_byte_sz'(cpu_loader_max_len));
  endfunction

endpackage

// File: rtl/cpu_loader_xor.sv
// Running XOR accumulator over payload bytes, with synchronous clear and
// enable. Only built when CPU_LOADER_CHECKSUM_EN is defined.
module cpu_loader_xor
  import cpu_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          en,
  input  logic [cpu_loader_byte_sz-1:0] din,
  output logic [cpu_loader_byte_sz-1:0] acc
);

  // Clear wins over accumulate so a new frame always starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc ^ din;
  end

endmodule

// File: rtl/cpu_loader.sv
// Framed byte-stream program loader for cpu_cpu.
// Frame: LEN, LEN payload bytes, and a trailing XOR CHK byte when
// CPU_LOADER_CHECKSUM_EN is defined (default build: no checksum).
// Handshake: a byte transfers on a posedge with in_valid && in_ready;
// in_ready is high whenever reset is released, so the stream never stalls.
module cpu_loader
  import cpu_loader_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [cpu_loader_byte_sz-1:0]  in_data,
  output logic                           in_ready,
  output logic [cpu_code_sz-1:0]         code,
  output logic                           cpu_reset,
  output logic                           loaded,
  output logic                           error,
  output logic [cpu_loader_state_sz-1:0] state
);

  cpu_loader_state_e            state_q, state_d;
  logic [cpu_loader_cnt_sz-1:0] cnt_q;
  logic [cpu_loader_cnt_sz-1:0] len_q;
  logic                         accept;
  logic                         start;
  logic                         wr;
  logic                         go_err;
  logic                         last;

  assign in_ready = reset;
  assign accept   = in_valid && in_ready;
  assign last     = (cnt_q == len_q - cpu_loader_cnt_sz'(1));
  assign state    = state_q;

`ifdef CPU_LOADER_CHECKSUM_EN
  logic [cpu_loader_byte_sz-1:0] acc;

  cpu_loader_xor u_xor (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .en    (wr),
    .din   (in_data),
    .acc   (acc)
  );
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-byte datapath controls.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    wr      = 1'b0;
    go_err  = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (len_valid(in_data)) begin
            state_d = ST_DATA;
            start   = 1'b1;
          end else begin
            state_d = ST_ERR;
            go_err  = 1'b1;
          end
        end
        ST_DATA: begin
          wr = 1'b1;
          if (last) begin
`ifdef CPU_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_RUN;
`endif
          end
        end
`ifdef CPU_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (in_data == acc) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERR;
            go_err  = 1'b1;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Image, counter and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code      <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      cpu_reset <= 1'b1;
      loaded    <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (start) begin
        code  <= '0;
        cnt_q <= '0;
        len_q <= in_data[cpu_loader_cnt_sz-1:0];
        error <= 1'b0;
      end else if (wr) begin
        code[{cnt_q[cpu_loader_cnt_sz-2:0], 3'b000} +: cpu_loader_byte_sz] <= in_data;
        cnt_q <= cnt_q + cpu_loader_cnt_sz'(1);
      end
      if (go_err) error <= 1'b1;
      cpu_reset <= (state_d != ST_RUN);
      loaded    <= (state_d == ST_RUN);
    end
  end

endmodule

// File: tb/tb_cpu_loader.sv
// Directed bench for cpu_loader. Works for both builds; the CHK byte is
// appended only when CPU_LOADER_CHECKSUM_EN is defined.
module tb_cpu_loader;
  import cpu_loader_pkg::*;

  logic                           clk = 1'b0;
  logic                           reset = 1'b0;
  logic                           in_valid = 1'b0;
  logic [7:0]                     in_data = 8'h00;
  logic                           in_ready;
  logic [cpu_code_sz-1:0]         code;
  logic                           cpu_reset;
  logic                           loaded;
  logic                           error;
  logic [cpu_loader_state_sz-1:0] state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]             payload [32];
  logic [cpu_code_sz-1:0] exp_code;

  cpu_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .code      (code),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .error     (error),
    .state     (state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [cpu_code_sz-1:0] obs,
                       input logic [cpu_code_sz-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte for one edge; outputs are sampled 1 ns after that edge.
  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Expected image: payload bytes 0..len-1, zeros above.
  function automatic logic [cpu_code_sz-1:0] model_code(input int len);
    logic [cpu_code_sz-1:0] m = '0;
    for (int i = 0; i < len; i++) m[8*i +: 8] = payload[i];
    return m;
  endfunction

  // Back-to-back frame; cpu_reset must still be held before the final byte.
  task automatic send_frame(input int len, input logic [7:0] chk_xor, input string tag);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) begin
`ifndef CPU_LOADER_CHECKSUM_EN
      if (i == len - 1) check({tag, "_hold"}, cpu_reset, 1);
`endif
      send_byte(payload[i]);
    end
`ifdef CPU_LOADER_CHECKSUM_EN
    check({tag, "_hold"}, cpu_reset, 1);
    send_byte(chk_xor);
`endif
    bus_idle();
  endtask

  function automatic logic [7:0] xor_of(input int len);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < len; i++) x ^= payload[i];
    return x;
  endfunction

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_code", code, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_loaded", loaded, 0);
    check("rst_error", error, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_state", state, cpu_loader_state_idle);

    // Basic frame LEN=3.
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    send_frame(3, 8'h00, "f3");
    check("f3_code", code, 256'h332211);
    check("f3_cpu_reset", cpu_reset, 0);
    check("f3_loaded", loaded, 1);
    check("f3_error", error, 0);
    check("f3_state", state, cpu_loader_state_run);

    // Reset mid-frame aborts asynchronously.
    send_byte(8'd4);
    send_byte(8'hAA);
    check("mid_cpu_reset", cpu_reset, 1);
    check("mid_code", code, 256'hAA);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_code", code, 0);
    check("mid_rst_cpu_reset", cpu_reset, 1);
    check("mid_rst_loaded", loaded, 0);
    check("mid_rst_state", state, cpu_loader_state_idle);
    bus_idle();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rel_in_ready", in_ready, 1);

`ifdef CPU_LOADER_CHECKSUM_EN
    // Bad checksum keeps the partial image and holds the CPU.
    send_byte(8'd3); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h55);
    bus_idle();
    check("badchk_error", error, 1);
    check("badchk_cpu_reset", cpu_reset, 1);
    check("badchk_loaded", loaded, 0);
    check("badchk_code", code, 256'h332211);
    send_frame(3, 8'h00, "goodchk");
    check("goodchk_error", error, 0);
    check("goodchk_loaded", loaded, 1);
`endif

    // LEN=0 rejected; next byte is a new LEN which clears error.
    send_byte(8'd0);
    check("len0_error", error, 1);
    check("len0_cpu_reset", cpu_reset, 1);
    check("len0_state", state, cpu_loader_state_err);
    payload[0] = 8'h01; payload[1] = 8'h02;
    send_byte(8'd2);
    check("len0_next_error", error, 0);
    check("len0_next_state", state, cpu_loader_state_data);
    // A cycle without in_valid must not write anything.
    in_valid = 1'b0; in_data = 8'hFF;
    @(posedge clk); #1;
    check("gap_code", code, 0);
    send_byte(8'h01);
`ifndef CPU_LOADER_CHECKSUM_EN
    check("l2_hold", cpu_reset, 1);
`endif
    send_byte(8'h02);
`ifdef CPU_LOADER_CHECKSUM_EN
    check("l2_hold", cpu_reset, 1);
    send_byte(8'h03);
`endif
    bus_idle();
    check("l2_code", code, 256'h0201);
    check("l2_loaded", loaded, 1);
    check("l2_cpu_reset", cpu_reset, 0);

    // LEN=33 rejected.
    send_byte(8'd33);
    bus_idle();
    check("len33_error", error, 1);
    check("len33_loaded", loaded, 0);
    check("len33_cpu_reset", cpu_reset, 1);

    // LEN=32 fills the whole image.
    for (int i = 0; i < 32; i++) payload[i] = 8'(i * 7 + 3);
    exp_code = model_code(32);
    send_frame(32, xor_of(32), "f32");
    check("f32_code", code, exp_code);
    check("f32_loaded", loaded, 1);
    check("f32_error", error, 0);

    // New frame while running: CPU is held on the LEN edge.
    send_byte(8'd1);
    check("rerun_len_cpu_reset", cpu_reset, 1);
    check("rerun_len_loaded", loaded, 0);
    check("rerun_len_code", code, 0);
    send_byte(8'hAB);
`ifdef CPU_LOADER_CHECKSUM_EN
    send_byte(8'hAB);
`endif
    bus_idle();
    check("rerun_code", code, 256'hAB);
    check("rerun_cpu_reset", cpu_reset, 0);
    check("rerun_loaded", loaded, 1);

    repeat (2) @(posedge clk);
    #1;
    check("hold_loaded", loaded, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_loader.md
Name: cpu_loader

Overview:
- Upstream stage of cpu_cpu: receives a program as a framed byte stream over a valid/ready handshake.
- Assembles the flat code image consumed by cpu_cpu's code input.
- Holds the CPU in reset until a complete, valid frame has been stored.
- Releases the CPU to run after the frame is stored; a new frame may be loaded at any time.

Parameters:
code_sz, 256, width of code image in bits (matches cpu_code_sz)
byte_sz, 8, width of one stream byte
max_len, 32, maximum payload bytes per frame (code_sz / byte_sz)

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  asynchronous, active-low; low clears all state immediately
in_valid  input  1  upstream byte valid
in_data  input  byte_sz  upstream byte
in_ready  output  1  loader accepts byte this cycle
code  output  code_sz  program image to cpu_cpu
cpu_reset  output  1  active-high hold for cpu_cpu reset input
loaded  output  1  high while a verified image is running
error  output  1  high after a rejected frame, until next frame starts

Behaviour:
- Reset (reset low, asynchronous) values:
  - state=IDLE, code=0, cpu_reset=1, loaded=0, error=0.
  - Byte counter=0, checksum accumulator=0.
  - in_ready=1 once reset is released.
- Transfer rule: a byte transfers only on a posedge with in_valid && in_ready.
  - in_ready is 1 in every state. The loader never stalls the stream.
- Frame format: LEN byte, then LEN payload bytes, then (with checksum feature) one CHK byte.
- States:
  - IDLE: next accepted byte is LEN.
    - LEN in 1..max_len -> DATA; code cleared to 0, counter=0, accumulator=0, error=0.
    - LEN=0 or LEN>max_len -> ERR; error=1.
  - DATA: accepted byte k (0-based) written to code[8k+7:8k]; accumulator ^= byte; counter++.
    - After byte LEN-1 -> CHECK (checksum feature on) or RUN (feature off).
  - CHECK: accepted byte compared to accumulator.
    - Equal -> RUN.
    - Unequal -> ERR; error=1; code retains the partial image; cpu_reset stays 1.
  - RUN: cpu_reset=0, loaded=1.
    - cpu_reset deasserts on the posedge that accepts the final byte, so the CPU executes on the next edge.
    - An accepted byte in RUN is a new LEN: cpu_reset=1 and loaded=0 take effect on that same edge, then LEN is evaluated exactly as in IDLE.
  - ERR: cpu_reset=1, loaded=0.
    - Next accepted byte is LEN, evaluated as in IDLE; a valid LEN clears error.
- Output timing:
  - cpu_reset is 1 in IDLE, DATA, CHECK and ERR.
  - cpu_reset and loaded are registered, not combinational from in_valid.
- Unwritten bytes (index >= LEN) read 0. Opcode 0 is therefore what the CPU sees past the program end.
- Counter width: clog2(max_len)+1 bits, so LEN=max_len is reachable without wrap.
- A byte accepted with in_valid high continuously is processed on every cycle, with no bubbles.
- Reset low mid-frame: abort immediately; all outputs return to their reset values.

Optional Feature:
- Macro: CPU_LOADER_CHECKSUM_EN.
- Defined: CHECK state exists; frame carries a trailing XOR checksum byte; a mismatch goes to ERR.
- Undefined:
  - No CHECK state and no accumulator logic.
  - DATA moves directly to RUN after the last payload byte.
  - error is raised only by a bad LEN.

Decomposition:
- Shared package (alongside cpu_code_sz and the cpu_cmp_state_* parameters):
  - cpu_loader_state_sz and cpu_loader_state_idle/data/check/run/err encodings.
  - cpu_loader_max_len.
- Sub-module cpu_loader_xor: running XOR accumulator with clear and enable. Instantiated only under CPU_LOADER_CHECKSUM_EN.

Test Plan:
- Reset low mid-stream, then high -> code=0, cpu_reset=1, loaded=0, error=0, in_ready=1.
- Frame LEN=3, bytes 0x11 0x22 0x33, CHK=0x00 -> code[23:0]=0x332211, upper bits 0. cpu_reset falls on the CHK-accept edge; loaded=1.
- Same frame with CHK=0x55 -> error=1, cpu_reset stays 1, loaded=0. Then a good frame clears error and runs.
- LEN=0, then separately LEN=33 -> error=1 each time, next byte treated as LEN. LEN=32 with 32 bytes fills all of code.
- While in RUN, send LEN=1, 0xAB, CHK=0xAB -> cpu_reset=1 on the LEN edge, code=0x...00AB with all other bytes 0, then RUN again.
- Build without CPU_LOADER_CHECKSUM_EN: LEN=2, 0x01 0x02 -> RUN after second byte, code[15:0]=0x0201. The next byte is treated as a new LEN.
